uart_rx_fifo: RTL and testbench

//  8N1 UART receiver for the management SoC, the chip-side counterpart of the bench UART transmitter.

---
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with programmable baud divider, framing check and a small
// first-word-fall-through receive FIFO with sticky framing/overrun flags.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rxs low with rx_en set
// S_START | timing half a bit to re-check the start bit
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | sampling the stop bit; push on 1, framing error on 0
// S_BRK   | framing error seen, waiting for the line to return high
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      cfg_divider,
  input  logic             rx_en,
  input  logic             ser_rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] rx_level,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [31:0]      cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [LVL_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic [31:0]      div_c, half_c;
  logic             tc_c, push_c, ferr_set_c, pop_c, full_c, wr_c, ovr_set_c;
  logic [LVL_W-1:0] level_c;

  assign div_c   = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;
  assign half_c  = div_c >> 1;
  assign tc_c    = (cnt_q == 32'd0);
  assign level_c = wptr_q - rptr_q;

  // Down-counter always reaches zero, so a divider change mid-frame cannot stall the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = tc_c ? cnt_q : cnt_q - 32'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = half_c - 32'd1;
        end
      end
      S_START: begin
        if (tc_c) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = div_c - 32'd1;
            bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (tc_c) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = div_c - 32'd1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tc_c) begin
          if (rxs_q) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set_c = 1'b1;
            state_d    = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_en) begin
      state_d    = S_IDLE;
      push_c     = 1'b0;
      ferr_set_c = 1'b0;
    end
  end

  assign full_c    = (level_c == LVL_W'(FIFO_DEPTH));
  assign pop_c     = (level_c != '0) && rx_ready;
  assign wr_c      = push_c && (!full_c || pop_c);
  assign ovr_set_c = push_c && full_c && !pop_c;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_c) begin
      mem_d[wptr_q[AW-1:0]] = shift_q;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_c) rptr_d = rptr_q + 1'b1;
    frame_err_d = (frame_err_q && !err_clr) || ferr_set_c;
    overrun_d   = (overrun_q && !err_clr) || ovr_set_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q     <= ser_rx;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_data   = mem_q[rptr_q[AW-1:0]];
  assign rx_valid  = (level_c != '0);
  assign rx_level  = level_c;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame scenarios plus randomized
// byte bursts compared against a queue-based model of the receive FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] cfg_divider = 32'd16;
  logic        rx_en = 1'b1;
  logic        ser_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  rx_level;
  logic        frame_err;
  logic        overrun;
  logic        err_clr = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic       exp_ferr, exp_ovr;

  uart_rx_fifo #(.FIFO_DEPTH(4), .LVL_W(3)) dut (
    .clk(clk), .resetn(resetn), .cfg_divider(cfg_divider), .rx_en(rx_en),
    .ser_rx(ser_rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of an 8N1 frame, d cycles per bit, then idles high.
  task automatic send(input logic [7:0] b, input logic stop, input int d, input int nbits = 10);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ser_rx = frame[i];
      tick(d);
    end
    ser_rx = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, rx_valid, 1'b1);
    chk({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int n;
    int d;
    int nfr;
    logic [7:0] b;
    logic stop;

    tick(3);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_level", rx_level, 3'd0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    resetn = 1'b1;
    tick(3);

    // 1: latency of a single good frame
    cfg_divider = 32'd16;
    n = 0;
    fork
      send(8'hA5, 1'b1, 16);
      begin
        while (n < 400) begin
          tick(1);
          n++;
          if (rx_valid) break;
        end
      end
    join
    chk("t1_latency", n, 155);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_level", rx_level, 3'd1);
    chk("t1_flags", {frame_err, overrun}, 2'b00);
    pop_chk("t1_pop", 8'hA5);
    tick(5);

    // 2: short glitch is rejected
    ser_rx = 1'b0;
    tick(5);
    ser_rx = 1'b1;
    tick(40);
    chk("t2_level", rx_level, 3'd0);
    chk("t2_flags", {frame_err, overrun}, 2'b00);

    // 3: framing error followed by a held-low line
    send(8'h3C, 1'b0, 16);
    ser_rx = 1'b0;
    tick(40);
    chk("t3_ferr", frame_err, 1'b1);
    chk("t3_level", rx_level, 3'd0);
    ser_rx = 1'b1;
    tick(10);
    chk("t3_level_after_break", rx_level, 3'd0);
    clear_flags();
    chk("t3_ferr_clr", frame_err, 1'b0);
    send(8'h5A, 1'b1, 16);
    tick(4);
    pop_chk("t3_next", 8'h5A);

    // 4: overrun on a fifth byte while full
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, 16);
      tick(3);
    end
    chk("t4_level", rx_level, 3'd4);
    chk("t4_ovr", overrun, 1'b1);
    for (int i = 1; i <= 4; i++) pop_chk("t4_pop", 8'(i));
    chk("t4_empty", rx_valid, 1'b0);
    clear_flags();
    chk("t4_ovr_clr", overrun, 1'b0);

    // 5: pop on the exact push cycle while full
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b1, 16);
      tick(3);
    end
    fork
      send(8'h05, 1'b1, 16);
      begin
        tick(154);
        chk("t5_head_at_push", rx_data, 8'h01);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(3);
    chk("t5_ovr", overrun, 1'b0);
    chk("t5_level", rx_level, 3'd4);
    for (int i = 2; i <= 5; i++) pop_chk("t5_pop", 8'(i));

    // rx_en low: frames are ignored
    rx_en = 1'b0;
    send(8'hEE, 1'b1, 16);
    tick(4);
    chk("dis_level", rx_level, 3'd0);
    rx_en = 1'b1;
    tick(4);

    // 6: async reset mid-frame
    send(8'h77, 1'b1, 16);
    send(8'h11, 1'b0, 16);
    tick(4);
    chk("t6_pre_level", rx_level, 3'd1);
    chk("t6_pre_ferr", frame_err, 1'b1);
    send(8'h55, 1'b1, 16, 5);
    ser_rx = 1'b1;
    tick(8);
    #1 resetn = 1'b0;
    #2;
    chk("t6_rst_outputs", {rx_data, rx_valid, rx_level, frame_err, overrun}, 14'd0);
    tick(2);
    resetn = 1'b1;
    tick(40);
    send(8'h81, 1'b1, 16);
    tick(3);
    chk("t6_level", rx_level, 3'd1);
    pop_chk("t6_pop", 8'h81);

    // randomized bursts against the queue model
    for (int r = 0; r < 10; r++) begin
      d = $urandom_range(0, 12);
      cfg_divider = 32'(d);
      if (d < 2) d = 2;
      nfr = $urandom_range(1, 6);
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovr = 1'b0;
      for (int k = 0; k < nfr; k++) begin
        b = 8'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        send(b, stop, d);
        tick(3);
        if (!stop) exp_ferr = 1'b1;
        else if (exp_q.size() < 4) exp_q.push_back(b);
        else exp_ovr = 1'b1;
      end
      chk("rnd_level", rx_level, 32'(exp_q.size()));
      chk("rnd_ferr", frame_err, exp_ferr);
      chk("rnd_ovr", overrun, exp_ovr);
      while (exp_q.size() > 0) pop_chk("rnd_pop", exp_q.pop_front());
      chk("rnd_empty", rx_valid, 1'b0);
      clear_flags();
      chk("rnd_clr", {frame_err, overrun}, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
